// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and types for the data-memory arbiter.
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - requester ids (PORT_A = CPU load/store, PORT_B = debug scanner)
//   - default address/data widths of the 64-word data memory
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle between the two requesters, the arbiter and
// the single-port data memory.
//   A_* / B_*  : level request (Req/Write/Addr/WData) in, RData/Ack pulse out
//   Mem_*      : memory word address, write data, write enable
//   M_R_Data   : combinational memory read data
// Modports: slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              A_Req, A_Write, A_Ack;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_WData, A_RData;
  logic              B_Req, B_Write, B_Ack;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_WData, B_RData;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] M_W_Data, M_R_Data;
  logic              Mem_Write;

  modport slave (
    input  A_Req, A_Write, A_Addr, A_WData,
    output A_RData, A_Ack,
    input  B_Req, B_Write, B_Addr, B_WData,
    output B_RData, B_Ack,
    output Mem_Addr, M_W_Data, Mem_Write,
    input  M_R_Data
  );

  modport master (
    output A_Req, A_Write, A_Addr, A_WData,
    input  A_RData, A_Ack,
    output B_Req, B_Write, B_Addr, B_WData,
    input  B_RData, B_Ack,
    input  Mem_Addr, M_W_Data, Mem_Write,
    output M_R_Data
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req_a/req_b : pending requests
//   last_grant  : id of the port served last (PORT_A/PORT_B)
//   grant_valid : any request pending
//   grant_id    : winner; on a tie the port that was not served last wins
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = req_a | req_b;
  assign grant_id    = (req_a && req_b) ? ~last_grant : (req_b ? PORT_B : PORT_A);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer for the single-port 64-word
// data memory. One access per IDLE->ACCESS->RESP pass: operands are latched
// when IDLE samples a request, the memory is driven for one cycle in ACCESS,
// and the winner gets registered read data plus a one-cycle Ack in RESP.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : A/B requester handshakes and memory signals
//   Busy            : high while not IDLE
//   A_Count/B_Count : saturating per-port access counters, only when
//                     DMEM_ARB_STATS_EN is defined
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  dmem_arbiter_if.slave bus,
`ifdef DMEM_ARB_STATS_EN
  output logic [CNT_W-1:0] A_Count,
  output logic [CNT_W-1:0] B_Count,
`endif
  output logic Busy
);
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("dmem_arbiter: CNT_W must be at least 1");
  end

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic              busy_q, busy_d;
  logic              grant_valid, grant_id;

  rr_arb2 u_rr (
    .req_a       (bus.A_Req),
    .req_b       (bus.B_Req),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    case (state_q)
      S_IDLE: if (grant_valid) begin
        // Mem_* registers double as the operand latch for ACCESS.
        id_d        = grant_id;
        mem_addr_d  = (grant_id == PORT_B) ? bus.B_Addr  : bus.A_Addr;
        mem_wdata_d = (grant_id == PORT_B) ? bus.B_WData : bus.A_WData;
        mem_write_d = (grant_id == PORT_B) ? bus.B_Write : bus.A_Write;
        state_d     = S_ACCESS;
      end
      S_ACCESS: begin
        // mem_write_q still holds the latched access type here.
        if (!mem_write_q) begin
          if (id_q == PORT_A) a_rdata_d = bus.M_R_Data;
          else                b_rdata_d = bus.M_R_Data;
        end
        a_ack_d = (id_q == PORT_A);
        b_ack_d = (id_q == PORT_B);
        state_d = S_RESP;
      end
      S_RESP: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= PORT_B;
      id_q        <= PORT_A;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.Mem_Addr  = mem_addr_q;
  assign bus.M_W_Data  = mem_wdata_q;
  assign bus.Mem_Write = mem_write_q;
  assign bus.A_RData   = a_rdata_q;
  assign bus.B_RData   = b_rdata_q;
  assign bus.A_Ack     = a_ack_q;
  assign bus.B_Ack     = b_ack_q;
  assign Busy          = busy_q;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (state_q == S_RESP) begin
      if (id_q == PORT_A && a_cnt_q != '1) a_cnt_d = a_cnt_q + 1'b1;
      if (id_q == PORT_B && b_cnt_q != '1) b_cnt_d = b_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign A_Count = a_cnt_q;
  assign B_Count = b_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Directed vector
// table, hand sequences for round-robin and mid-access reset, and random
// traffic checked against a transaction-timestamp reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TB_CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [TB_CNT_W-1:0] a_count, b_count;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef DMEM_ARB_STATS_EN
    .A_Count (a_count),
    .B_Count (b_count),
`endif
    .Busy  (busy)
  );

  // memory under the arbiter
  logic [DW-1:0] mem [64];
  assign bus.M_R_Data = mem[bus.Mem_Addr];
  always @(posedge clk) if (bus.Mem_Write) mem[bus.Mem_Addr] <= bus.M_W_Data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction timestamps) ----------------
  logic [DW-1:0] ref_mem [64];
  int  e, free_at, tN;
  bit  act, win, last, twr;
  logic [AW-1:0] taddr;
  logic [DW-1:0] twd;
  bit  x_mw, x_aack, x_back, x_busy;
  logic [AW-1:0] x_ma;
  logic [DW-1:0] x_md, x_ard, x_brd;
  int  x_ac, x_bc;
  localparam int CMAX = (1 << TB_CNT_W) - 1;

  task automatic model_reset();
    e = 0; free_at = 0; act = 0; last = 1; win = 0;
    x_mw = 0; x_aack = 0; x_back = 0; x_busy = 0;
    x_ma = '0; x_md = '0; x_ard = '0; x_brd = '0; x_ac = 0; x_bc = 0;
  endtask

  // Called just after each rising edge, before new inputs are driven.
  task automatic model_edge();
    x_mw = 0; x_aack = 0; x_back = 0;
    if (act && e == tN + 1) begin
      if (twr) ref_mem[taddr] = twd;
      else if (win) x_brd = ref_mem[taddr];
      else x_ard = ref_mem[taddr];
      if (win) x_back = 1; else x_aack = 1;
    end
    if (act && e == tN + 2) begin
      if (win) begin if (x_bc < CMAX) x_bc++; end
      else begin if (x_ac < CMAX) x_ac++; end
    end
    if (e >= free_at && (bus.A_Req || bus.B_Req)) begin
      win = (bus.A_Req && bus.B_Req) ? !last : bus.B_Req;
      last = win; act = 1; tN = e; free_at = e + 3;
      twr   = win ? bus.B_Write : bus.A_Write;
      taddr = win ? bus.B_Addr  : bus.A_Addr;
      twd   = win ? bus.B_WData : bus.A_WData;
      x_ma = taddr; x_md = twd; x_mw = twr;
    end
    x_busy = (e < free_at - 1);
    e++;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".mem_write"}, bus.Mem_Write, x_mw);
    chk({tag, ".mem_addr"},  bus.Mem_Addr,  x_ma);
    chk({tag, ".m_w_data"},  bus.M_W_Data,  x_md);
    chk({tag, ".a_ack"},     bus.A_Ack,     x_aack);
    chk({tag, ".b_ack"},     bus.B_Ack,     x_back);
    chk({tag, ".a_rdata"},   bus.A_RData,   x_ard);
    chk({tag, ".b_rdata"},   bus.B_RData,   x_brd);
    chk({tag, ".busy"},      busy,          x_busy);
    chk({tag, ".ack_excl"},  bus.A_Ack & bus.B_Ack, 0);
`ifdef DMEM_ARB_STATS_EN
    chk({tag, ".a_count"},   a_count, x_ac);
    chk({tag, ".b_count"},   b_count, x_bc);
`endif
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
  endtask

  task automatic clr_inputs();
    bus.A_Req = 0; bus.A_Write = 0; bus.A_Addr = '0; bus.A_WData = '0;
    bus.B_Req = 0; bus.B_Write = 0; bus.B_Addr = '0; bus.B_WData = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_write"}, bus.Mem_Write, 0);
    chk({tag, ".mem_addr"},  bus.Mem_Addr, 0);
    chk({tag, ".m_w_data"},  bus.M_W_Data, 0);
    chk({tag, ".acks"},      {bus.A_Ack, bus.B_Ack}, 0);
    chk({tag, ".a_rdata"},   bus.A_RData, 0);
    chk({tag, ".b_rdata"},   bus.B_RData, 0);
    chk({tag, ".busy"},      busy, 0);
  endtask

  task automatic do_reset(input bit check);
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      bus.A_Req = 1'($urandom); bus.A_Write = 1'($urandom); bus.A_Addr = AW'($urandom);
      bus.A_WData = $urandom;
      bus.B_Req = 1'($urandom); bus.B_Write = 1'($urandom); bus.B_Addr = AW'($urandom);
      bus.B_WData = $urandom;
      @(negedge clk);
      if (check) chk_zero("reset");
    end
    clr_inputs();
    @(negedge clk);
    rst_n = 1;
    model_reset();
    if (check) begin
      step();
      chk_zero("post_reset_idle");
    end
  endtask

  task automatic set_ops(input int p);
    if (p == 0) begin
      bus.A_Write = 1'($urandom); bus.A_Addr = AW'($urandom_range(0, 15)); bus.A_WData = $urandom;
    end else begin
      bus.B_Write = 1'($urandom); bus.B_Addr = AW'($urandom_range(0, 15)); bus.B_WData = $urandom;
    end
  endtask

  task automatic xfer(input bit p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    if (p) begin bus.B_Req = 1; bus.B_Write = wr; bus.B_Addr = a; bus.B_WData = d; end
    else   begin bus.A_Req = 1; bus.A_Write = wr; bus.A_Addr = a; bus.A_WData = d; end
    for (int k = 0; k < 6 && !got; k++) begin
      step();
      if (p ? bus.B_Ack : bus.A_Ack) got = 1;
    end
    chk("xfer_ack_seen", got, 1);
    step();
    bus.A_Req = 0; bus.B_Req = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit a_req, a_wr; logic [AW-1:0] a_addr; logic [DW-1:0] a_wd;
    bit b_req, b_wr; logic [AW-1:0] b_addr; logic [DW-1:0] b_wd;
    bit mw; logic [AW-1:0] ma; logic [DW-1:0] md;
    bit aack, back; logic [DW-1:0] ard, brd; bit bsy;
  } vec_t;
  vec_t tbl [7];

  bit pend [2];
  bit rel  [2];

  initial begin
    int ack_cnt;
    int cur;

    tbl[0] = '{1'b1,1'b1,6'h05,32'h1111_2222, 1'b0,1'b0,6'h00,32'h0,
               1'b1,6'h05,32'h1111_2222, 1'b0,1'b0,32'h0,32'h0, 1'b1};
    tbl[1] = '{1'b1,1'b1,6'h05,32'h1111_2222, 1'b0,1'b0,6'h00,32'h0,
               1'b0,6'h05,32'h1111_2222, 1'b1,1'b0,32'h0,32'h0, 1'b1};
    tbl[2] = '{1'b1,1'b1,6'h05,32'h1111_2222, 1'b0,1'b0,6'h00,32'h0,
               1'b0,6'h05,32'h1111_2222, 1'b0,1'b0,32'h0,32'h0, 1'b0};
    tbl[3] = '{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h05,32'hDEAD_BEEF,
               1'b0,6'h05,32'hDEAD_BEEF, 1'b0,1'b0,32'h0,32'h0, 1'b1};
    tbl[4] = '{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h05,32'hDEAD_BEEF,
               1'b0,6'h05,32'hDEAD_BEEF, 1'b0,1'b1,32'h0,32'h1111_2222, 1'b1};
    tbl[5] = '{1'b0,1'b0,6'h00,32'h0, 1'b1,1'b0,6'h05,32'hDEAD_BEEF,
               1'b0,6'h05,32'hDEAD_BEEF, 1'b0,1'b0,32'h0,32'h1111_2222, 1'b0};
    tbl[6] = '{1'b0,1'b0,6'h00,32'h0, 1'b0,1'b0,6'h05,32'hDEAD_BEEF,
               1'b0,6'h05,32'hDEAD_BEEF, 1'b0,1'b0,32'h0,32'h1111_2222, 1'b0};

    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    clr_inputs();
    model_reset();

    // reset state with random inputs
    do_reset(1);

    // A write to 0x05, then B read of 0x05
    for (int i = 0; i < 7; i++) begin
      bus.A_Req = tbl[i].a_req; bus.A_Write = tbl[i].a_wr;
      bus.A_Addr = tbl[i].a_addr; bus.A_WData = tbl[i].a_wd;
      bus.B_Req = tbl[i].b_req; bus.B_Write = tbl[i].b_wr;
      bus.B_Addr = tbl[i].b_addr; bus.B_WData = tbl[i].b_wd;
      step();
      chk($sformatf("vec%0d.mem_write", i), bus.Mem_Write, tbl[i].mw);
      chk($sformatf("vec%0d.mem_addr", i),  bus.Mem_Addr,  tbl[i].ma);
      chk($sformatf("vec%0d.m_w_data", i),  bus.M_W_Data,  tbl[i].md);
      chk($sformatf("vec%0d.a_ack", i),     bus.A_Ack,     tbl[i].aack);
      chk($sformatf("vec%0d.b_ack", i),     bus.B_Ack,     tbl[i].back);
      chk($sformatf("vec%0d.a_rdata", i),   bus.A_RData,   tbl[i].ard);
      chk($sformatf("vec%0d.b_rdata", i),   bus.B_RData,   tbl[i].brd);
      chk($sformatf("vec%0d.busy", i),      busy,          tbl[i].bsy);
    end

    // both ports requesting continuously: A,B,A,B every 3 cycles
    do_reset(0);
    bus.A_Req = 1; bus.A_Write = 0; bus.A_Addr = 6'h03;
    bus.B_Req = 1; bus.B_Write = 0; bus.B_Addr = 6'h04;
    ack_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("rr_busy%0d", c), busy, (c % 3) != 2);
      chk("rr_ack_excl", bus.A_Ack & bus.B_Ack, 0);
      if (bus.A_Ack || bus.B_Ack) begin
        chk("rr_ack_cycle", c, 3 * ack_cnt + 1);
        chk("rr_ack_port", bus.B_Ack, ack_cnt % 2);
        ack_cnt++;
      end
    end
    chk("rr_ack_count", ack_cnt, 4);
    clr_inputs();

    // reset during ACCESS of an A write
    do_reset(0);
    bus.A_Req = 1; bus.A_Write = 1; bus.A_Addr = 6'h2A; bus.A_WData = 32'hCAFE_0001;
    step();
    chk("abort_mw_before", bus.Mem_Write, 1);
    #2;
    rst_n = 0;
    bus.A_Req = 0;
    #1;
    chk("abort_mw_now", bus.Mem_Write, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_no_ack", bus.A_Ack, 0);
      chk("abort_idle", busy, 0);
    end
    bus.A_Req = 1; bus.A_Write = 0; bus.A_Addr = 6'h11;
    step();
    step();
    chk("after_abort_ack", bus.A_Ack, 1);
    chk("after_abort_rdata", bus.A_RData, ref_mem[6'h11]);
    step();
    clr_inputs();

    // random traffic against the reference model
    do_reset(0);
    pend[0] = 0; pend[1] = 0; rel[0] = 0; rel[1] = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      compare_model("rand");
      cur = e - 1;
      for (int p = 0; p < 2; p++) begin
        if (rel[p]) begin rel[p] = 0; pend[p] = 0; end
        if ((p == 0 && x_aack) || (p == 1 && x_back)) rel[p] = 1;
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          set_ops(p);
        end else if (!pend[p] || (act && int'(win) == p && cur >= tN && cur <= tN + 1)) begin
          set_ops(p);
        end
      end
      bus.A_Req = pend[0];
      bus.B_Req = pend[1];
    end
    clr_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      compare_model("drain");
    end

`ifdef DMEM_ARB_STATS_EN
    do_reset(0);
    for (int i = 0; i < 5; i++) xfer(1'b0, 1'b0, AW'(i), 32'h0);
    for (int i = 0; i < 2; i++) xfer(1'b1, 1'b1, AW'(i + 8), $urandom);
    chk("stats_a_count", a_count, 3);
    chk("stats_b_count", b_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, tests %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
